// File: rtl/fc_output_collector.sv
// Purpose: gathers one frame of OUTPUT_NODES layer results, then replays it in node order.
// Latency: first output word is valid 2 cycles after the edge that accepts the final input word.
// Backpressure: in_ready is low for the whole drain; out_ready stalls hold the output word stable.
//
// Ports:
//   clk, reset       single clock, asynchronous active-low reset
//   in_valid/in_data/in_ready                 result stream from the layer
//   out_valid/out_ready/out_data/out_index/out_last   replay stream
//   frame_done       one-cycle pulse after the out_last handshake
//   drop_err         sticky: an input arrived while in_ready was low
module fc_output_collector #(
  parameter int DATA_WIDTH   = 16,
  parameter int OUTPUT_NODES = 1200,
  parameter int IDX_WIDTH    = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]  out_index,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  drop_err
);

  if (OUTPUT_NODES < 2 || (2 ** IDX_WIDTH) < OUTPUT_NODES) begin : g_param_check
    $error("fc_output_collector: OUTPUT_NODES must be >= 2 and fit in IDX_WIDTH bits");
  end

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(OUTPUT_NODES - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t state;

  // Frame buffer; contents are not reset.
  logic [DATA_WIDTH-1:0] mem [OUTPUT_NODES];

  logic [IDX_WIDTH-1:0] wr_idx;
  logic [IDX_WIDTH-1:0] rd_idx;
  logic                 rd_done;   // every index of this frame has been read

  // Read stage: registered RAM output plus the index/last tag of that word.
  // Together with the output register it forms a two-entry pipeline, so a
  // read can be issued every cycle while the output keeps moving.
  logic                  r_vld;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic                  r_last;

  logic in_acc;
  logic out_hs;
  logic o_load;
  logic rd_issue;

  assign in_acc = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Output register takes the read-stage word when empty or being consumed.
  assign o_load = r_vld & (~out_valid | out_ready);

  // A new read may be launched when the read stage is empty or draining
  // into the output register on this edge.
  assign rd_issue = (state == DRAIN) & ~rd_done & (~r_vld | o_load);

  // Write and read never coincide: writes happen only while collecting,
  // reads only while draining. The read register holds its word while the
  // pipeline is stalled (read enable low).
  always_ff @(posedge clk) begin
    if (in_acc) begin
      mem[wr_idx] <= in_data;
    end
    if (rd_issue) begin
      r_dat <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= COLLECT;
      wr_idx     <= '0;
      rd_idx     <= '0;
      rd_done    <= 1'b0;
      r_vld      <= 1'b0;
      r_idx      <= '0;
      r_last     <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // A word offered while not ready is lost; remember that it happened.
      if (in_valid && !in_ready) begin
        drop_err <= 1'b1;
      end

      case (state)
        COLLECT: begin
          if (in_valid) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx   <= '0;
              state    <= DRAIN;
              in_ready <= 1'b0;
            end else begin
              wr_idx <= wr_idx + IDX_ONE;
            end
          end
        end

        DRAIN: begin
          if (rd_issue) begin
            r_idx  <= rd_idx;
            r_last <= (rd_idx == LAST_IDX);
            if (rd_idx == LAST_IDX) begin
              rd_idx  <= '0;
              rd_done <= 1'b1;
            end else begin
              rd_idx <= rd_idx + IDX_ONE;
            end
          end
          // Last word handed off: the pipeline is empty by construction.
          if (out_hs && out_last) begin
            state      <= COLLECT;
            in_ready   <= 1'b1;
            frame_done <= 1'b1;
            rd_done    <= 1'b0;
          end
        end

        default: begin
          state <= COLLECT;
        end
      endcase

      if (rd_issue) begin
        r_vld <= 1'b1;
      end else if (o_load) begin
        r_vld <= 1'b0;
      end

      if (o_load) begin
        out_valid <= 1'b1;
        out_data  <= r_dat;
        out_index <= r_idx;
        out_last  <= r_last;
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fc_output_collector.sv
module tb_fc_output_collector;

  localparam int DW  = 16;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int BN  = 1200;
  localparam int BIW = 11;

  logic clk;
  logic reset;

  // Small instance (4 nodes)
  logic          in_valid, in_ready, out_valid, out_ready, out_last, frame_done, drop_err;
  logic [DW-1:0] in_data, out_data;
  logic [IW-1:0] out_index;

  // Default-parameter instance (1200 nodes)
  logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_frame_done, b_drop_err;
  logic [DW-1:0]  b_in_data, b_out_data;
  logic [BIW-1:0] b_out_index;

  fc_output_collector #(.DATA_WIDTH(DW), .OUTPUT_NODES(N), .IDX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last),
    .frame_done(frame_done), .drop_err(drop_err)
  );

  fc_output_collector dut_big (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_index(b_out_index), .out_last(b_out_last),
    .frame_done(b_frame_done), .drop_err(b_drop_err)
  );

  int vecs = 0;
  int miscompares = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int rdy_ph = 0;
  int sent = 0;
  int fd_cnt = 0;
  int hs_cnt = 0;
  int hs_cyc[$];
  logic [18:0] sbq[$];
  logic        stall_hold = 1'b0;
  logic [18:0] held = '0;
  int b_exp = 0;
  int b_last_cnt = 0;
  int b_fd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // out_ready drivers: mode 0 always ready, mode 1 pattern 1,0,0,1; big instance random.
  initial begin
    out_ready   = 1'b0;
    b_out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        out_ready = (rdy_ph == 0 || rdy_ph == 3);
        rdy_ph    = (rdy_ph + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
      b_out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Small-instance scoreboard monitor and stall-stability checker.
  always @(negedge clk) begin
    logic [18:0] expw;
    if (!reset) begin
      stall_hold = 1'b0;
    end else begin
      if (stall_hold) begin
        chk("hold_stable", {12'h0, out_valid, out_data, out_index, out_last}, {12'h0, 1'b1, held});
      end
      if (frame_done) fd_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        hs_cyc.push_back(cyc);
        expw = (sbq.size() > 0) ? sbq.pop_front() : 'x;
        chk("out_word", {13'h0, out_data, out_index, out_last}, {13'h0, expw});
      end
      stall_hold = out_valid && !out_ready;
      held       = {out_data, out_index, out_last};
    end
  end

  // Big-instance checker: data equals index, last only at 1199.
  always @(negedge clk) begin
    if (reset) begin
      if (b_frame_done) b_fd_cnt++;
      if (b_out_valid && b_out_ready) begin
        if (b_out_last) b_last_cnt++;
        chk("soak_word", {4'h0, b_out_data, b_out_index, b_out_last},
            {4'h0, 16'(b_exp), 11'(b_exp), (b_exp == BN - 1)});
        b_exp++;
      end
    end
  end

  task automatic send(input logic [15:0] d);
    logic [IW-1:0] ix;
    ix = IW'(sent);
    in_valid = 1'b1;
    in_data  = d;
    sbq.push_back({d, ix, (sent == N - 1)});
    sent = (sent + 1) % N;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid_low"}, 32'(out_valid), 32'd0);
    chk({tag, "_sb_empty"}, sbq.size(), 32'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int fd0;
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    b_in_valid = 1'b0;
    b_in_data  = '0;
    idle(3);

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    chk("rst_big_in_ready", 32'(b_in_ready), 32'd1);
    reset = 1'b1;
    idle(2);

    // Scenario 1: fill and full-speed drain, with latency and burst checks
    rdy_mode = 0;
    hs_cyc.delete();
    send(16'h3C00); send(16'h4000); send(16'h4200); send(16'h4400);
    @(negedge clk);
    chk("lat_in_ready_low", 32'(in_ready), 32'd0);
    chk("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_first_valid", 32'(out_valid), 32'd1);
    wait_done("s1");
    chk("s1_burst_count", hs_cyc.size(), 32'd4);
    if (hs_cyc.size() == 4) chk("s1_no_bubbles", 32'(hs_cyc[3] - hs_cyc[0]), 32'd3);

    // Scenario 2: back-pressured drain
    rdy_mode = 1;
    rdy_ph   = 0;
    send(16'h3C00); send(16'h4000); send(16'h4200); send(16'h4400);
    wait_done("s2");
    rdy_mode = 0;

    // Scenario 3: gapped input
    send(16'h3C00); send(16'h4000);
    idle(3);
    send(16'h4200);
    idle(1);
    @(negedge clk);
    chk("s3_still_collect", 32'(in_ready), 32'd1);
    chk("s3_no_early_out", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(16'h4400);
    wait_done("s3");

    // Scenario 4: word offered during drain is dropped
    send(16'h3C00); send(16'h4000); send(16'h4200); send(16'h4400);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("s4_drop_err_set", 32'(drop_err), 32'd1);
    wait_done("s4a");
    chk("s4_drop_err_sticky", 32'(drop_err), 32'd1);
    send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
    wait_done("s4b");
    chk("s4_drop_err_still", 32'(drop_err), 32'd1);

    // Scenario 5: reset after two output handshakes
    fd0 = hs_cnt;
    send(16'hA001); send(16'hA002); send(16'hA003); send(16'hA004);
    n = 0;
    while (hs_cnt < fd0 + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("s5_two_handshakes", 32'(hs_cnt - fd0), 32'd2);
    @(posedge clk);
    #2;
    fd0 = fd_cnt;
    reset = 1'b0;
    #1;
    chk("s5_async_out_valid", 32'(out_valid), 32'd0);
    chk("s5_async_in_ready", 32'(in_ready), 32'd1);
    chk("s5_async_out_data", 32'(out_data), 32'd0);
    chk("s5_async_out_index", 32'(out_index), 32'd0);
    chk("s5_async_out_last", 32'(out_last), 32'd0);
    chk("s5_async_drop_err", 32'(drop_err), 32'd0);
    sbq.delete();
    sent = 0;
    idle(2);
    reset = 1'b1;
    idle(4);
    chk("s5_no_frame_done", 32'(fd_cnt), 32'(fd0));
    chk("s5_idle_after_reset", 32'(out_valid), 32'd0);
    send(16'h5A01); send(16'h5A02); send(16'h5A03); send(16'h5A04);
    wait_done("s5");

    // Scenario 6: default-parameter soak with random out_ready
    b_exp      = 0;
    b_last_cnt = 0;
    b_fd_cnt   = 0;
    for (int i = 0; i < BN; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 16'(i);
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    n = 0;
    while (b_fd_cnt == 0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("soak_frame_done", 32'(b_fd_cnt), 32'd1);
    chk("soak_handshakes", 32'(b_exp), 32'(BN));
    chk("soak_last_count", 32'(b_last_cnt), 32'd1);
    chk("soak_in_ready", 32'(b_in_ready), 32'd1);
    chk("soak_drop_err", 32'(b_drop_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
